// File: rtl/spi_slave_cmd_ctrl_if.sv
// ============================================================================
//  Module      : spi_slave_cmd_ctrl_if
//  Description : Bundles the SPI slave handshake and the register bus that the
//                command controller sits between.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface spi_slave_cmd_ctrl_if #(
    parameter int PACK_LENGTH = 8
);
    // SPI slave side (raw, asynchronous to the system clock)
    logic                   IN_CS;
    logic                   IN_RX_READY;
    logic [PACK_LENGTH-1:0] IN_RX_DATA;
    logic [PACK_LENGTH-1:0] OUT_TX_DATA;

    // Register bus side
    logic [PACK_LENGTH-1:0] IN_REG_RDATA;
    logic [PACK_LENGTH-2:0] OUT_REG_ADDR;
    logic [PACK_LENGTH-1:0] OUT_REG_WDATA;
    logic                   OUT_REG_WR_EN;
    logic                   OUT_REG_RD_EN;

    // Status
    logic                   OUT_BUSY;
    logic                   OUT_ERR;

    // Controller view
    modport slave (
        input  IN_CS, IN_RX_READY, IN_RX_DATA, IN_REG_RDATA,
        output OUT_TX_DATA, OUT_REG_ADDR, OUT_REG_WDATA,
               OUT_REG_WR_EN, OUT_REG_RD_EN, OUT_BUSY, OUT_ERR
    );

    // Environment view (SPI slave + register file)
    modport master (
        output IN_CS, IN_RX_READY, IN_RX_DATA, IN_REG_RDATA,
        input  OUT_TX_DATA, OUT_REG_ADDR, OUT_REG_WDATA,
               OUT_REG_WR_EN, OUT_REG_RD_EN, OUT_BUSY, OUT_ERR
    );
endinterface

`default_nettype wire

// File: rtl/spi_slave_cmd_ctrl.sv
// ============================================================================
//  Module      : spi_slave_cmd_ctrl
//  Description : Command sequencer behind an SPI slave. Synchronises CS and the
//                word-ready flag, decodes {R/W, ADDR} + data frames and drives
//                a simple register bus; read data is loaded into the slave's
//                transmit word so it shifts out on the following frame.
//                Optional macro SPI_CMD_CTRL_AUTOINC_EN enables burst mode
//                (address auto-increment, unlimited words per CS low).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module spi_slave_cmd_ctrl #(
    parameter int                     PACK_LENGTH = 8,
    parameter int                     SYNC_STAGES = 2,
    parameter logic [PACK_LENGTH-1:0] IDLE_TX     = 8'hA5
) (
    input wire                   IN_CLK,
    input wire                   IN_RESET,
    spi_slave_cmd_ctrl_if.slave  bus
);

    localparam int ADDR_W = PACK_LENGTH - 1;
`ifdef SPI_CMD_CTRL_AUTOINC_EN
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};
`endif

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_CMD     = 4'd1,
        ST_WR_DATA = 4'd2,
        ST_WR_NEXT = 4'd3,
        ST_RD_REQ  = 4'd4,
        ST_RD_CAP  = 4'd5,
        ST_RD_WAIT = 4'd6,
        ST_RD_NEXT = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_cs_sync, r_rdy_sync;
    logic                   r_cs_prev, r_rdy_prev;
    logic [ADDR_W-1:0]      r_addr, w_addr_nxt;
    logic [PACK_LENGTH-1:0] r_wdata, w_wdata_nxt;
    logic [PACK_LENGTH-1:0] r_tx, w_tx_nxt;
    logic                   r_wr_en, w_wr_en_nxt;
    logic                   r_rd_en, w_rd_en_nxt;
    logic                   r_busy, w_busy_nxt;
    logic                   r_err, w_err_nxt;
    logic                   r_wr_seen, w_wr_seen_nxt;   // a data word was written this CS-low

    logic w_cs_s, w_rdy_s, w_cs_fall, w_cs_rise, w_frame;

    assign w_cs_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_rdy_s   = r_rdy_sync[SYNC_STAGES-1];
    assign w_cs_fall = r_cs_prev & ~w_cs_s;
    assign w_cs_rise = ~r_cs_prev & w_cs_s;
    assign w_frame   = w_rdy_s & ~r_rdy_prev;

    // Synchronise CS and READY into IN_CLK and keep the previous synced value for edge detect
    always_ff @(posedge IN_CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_cs_sync  <= '0;
            r_rdy_sync <= '0;
            r_cs_prev  <= 1'b0;
            r_rdy_prev <= 1'b0;
        end else begin
            r_cs_sync  <= {r_cs_sync[SYNC_STAGES-2:0], bus.IN_CS};
            r_rdy_sync <= {r_rdy_sync[SYNC_STAGES-2:0], bus.IN_RX_READY};
            r_cs_prev  <= w_cs_s;
            r_rdy_prev <= w_rdy_s;
        end
    end

    // State and output registers; all outputs are registered
    always_ff @(posedge IN_CLK or posedge IN_RESET) begin
        if (IN_RESET) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_tx      <= IDLE_TX;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_wr_seen <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_wdata   <= w_wdata_nxt;
            r_tx      <= w_tx_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_rd_en   <= w_rd_en_nxt;
            r_busy    <= w_busy_nxt;
            r_err     <= w_err_nxt;
            r_wr_seen <= w_wr_seen_nxt;
        end
    end

    // Next-state and next-output decode; a CS rise overrides after the frame is processed
    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_wdata_nxt   = r_wdata;
        w_tx_nxt      = r_tx;
        w_wr_en_nxt   = 1'b0;
        w_rd_en_nxt   = 1'b0;
        w_busy_nxt    = r_busy;
        w_err_nxt     = r_err;
        w_wr_seen_nxt = r_wr_seen;

        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_state_nxt   = ST_CMD;
                    w_err_nxt     = 1'b0;
                    w_busy_nxt    = 1'b1;
                    w_wr_seen_nxt = 1'b0;
                end
            end
            ST_CMD: begin
                if (w_frame) begin
                    w_addr_nxt = bus.IN_RX_DATA[ADDR_W-1:0];
                    if (bus.IN_RX_DATA[PACK_LENGTH-1]) begin
                        w_state_nxt = ST_RD_REQ;
                        w_rd_en_nxt = 1'b1;        // strobe is high for the whole RD_REQ cycle
                    end else begin
                        w_state_nxt = ST_WR_DATA;
                    end
                end
            end
            ST_WR_DATA: begin
                if (w_frame) begin
                    w_wdata_nxt   = bus.IN_RX_DATA;
                    w_wr_en_nxt   = 1'b1;
                    w_wr_seen_nxt = 1'b1;
                    w_state_nxt   = ST_WR_NEXT;
                end
            end
            ST_WR_NEXT: begin
                if (w_frame) w_err_nxt = 1'b1;
`ifdef SPI_CMD_CTRL_AUTOINC_EN
                w_addr_nxt  = r_addr + c_addr_one;
                w_state_nxt = ST_WR_DATA;
`else
                w_state_nxt = ST_DONE;
`endif
            end
            ST_RD_REQ: begin
                if (w_frame) w_err_nxt = 1'b1;     // word arrived before read data was ready
                w_state_nxt = ST_RD_CAP;
            end
            ST_RD_CAP: begin
                if (w_frame) w_err_nxt = 1'b1;
                w_tx_nxt    = bus.IN_REG_RDATA;
                w_state_nxt = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (w_frame) w_state_nxt = ST_RD_NEXT;
            end
            ST_RD_NEXT: begin
                if (w_frame) w_err_nxt = 1'b1;
`ifdef SPI_CMD_CTRL_AUTOINC_EN
                w_addr_nxt  = r_addr + c_addr_one;
                w_rd_en_nxt = 1'b1;
                w_state_nxt = ST_RD_REQ;
`else
                w_tx_nxt    = IDLE_TX;
                w_state_nxt = ST_DONE;
`endif
            end
            ST_DONE: begin
                if (w_frame) w_err_nxt = 1'b1;     // single mode takes no extra words
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_cs_rise) begin
            // Truncated: command alone, write data missing, or read abandoned mid-request.
            // In burst mode a rise in WR_DATA after a completed word is a normal end.
            if ((r_state == ST_CMD && w_frame) ||
                (r_state == ST_WR_DATA && !w_frame && !r_wr_seen) ||
                (r_state == ST_RD_REQ)) begin
                w_err_nxt = 1'b1;
            end
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = IDLE_TX;
            w_busy_nxt  = 1'b0;
            w_rd_en_nxt = 1'b0;                    // never start a read after the frame ends
        end
    end

    assign bus.OUT_TX_DATA   = r_tx;
    assign bus.OUT_REG_ADDR  = r_addr;
    assign bus.OUT_REG_WDATA = r_wdata;
    assign bus.OUT_REG_WR_EN = r_wr_en;
    assign bus.OUT_REG_RD_EN = r_rd_en;
    assign bus.OUT_BUSY      = r_busy;
    assign bus.OUT_ERR       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_cmd_ctrl.sv
// ============================================================================
//  Module      : tb_spi_slave_cmd_ctrl
//  Description : Self-checking bench for spi_slave_cmd_ctrl: table of single
//                transactions plus hand-written burst, truncation, gap and
//                reset sequences; register strobes checked against a queue.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_spi_slave_cmd_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_slave_cmd_ctrl_if #(.PACK_LENGTH(8)) bus ();

    spi_slave_cmd_ctrl #(
        .PACK_LENGTH (8),
        .SYNC_STAGES (2),
        .IDLE_TX     (8'hA5)
    ) dut (
        .IN_CLK   (clk),
        .IN_RESET (rst),
        .bus      (bus)
    );

    // Register file model: read data valid one cycle after RD_EN, garbage otherwise
    logic [7:0] mem [128];
    always @(posedge clk)
        bus.IN_REG_RDATA <= bus.OUT_REG_RD_EN ? mem[bus.OUT_REG_ADDR] : 8'hEE;

    typedef struct packed {
        logic       rd;
        logic [6:0] addr;
        logic [7:0] wdata;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] data;
        logic [7:0] rdata;
        logic [7:0] exp_tx_mid;
        logic       exp_err;
    } vec_t;
    vec_t vecs[6];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, exp);
        end
    endtask

    // Advance one clock, sample 1ns after the edge and score any register strobe
    task automatic tick();
        exp_t e;
        logic [17:0] got, want;
        @(posedge clk);
        #1;
        if (bus.OUT_REG_WR_EN || bus.OUT_REG_RD_EN) begin
            checks++;
            got = {bus.OUT_REG_RD_EN, bus.OUT_REG_WR_EN, bus.OUT_REG_ADDR,
                   bus.OUT_REG_RD_EN ? 8'h00 : bus.OUT_REG_WDATA};
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected got rd/wr/addr/wdata=%h required none", got);
            end else begin
                e    = exp_q.pop_front();
                want = {e.rd, ~e.rd, e.addr, e.rd ? 8'h00 : e.wdata};
                if (got !== want) begin
                    errors++;
                    $display("FAIL strobe got rd/wr/addr/wdata=%h required %h", got, want);
                end
            end
            if (bus.OUT_REG_WR_EN) mem[bus.OUT_REG_ADDR] = bus.OUT_REG_WDATA;
        end
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
        exp_t e;
        e = '{rd: 1'b0, addr: a, wdata: d};
        exp_q.push_back(e);
    endtask

    task automatic push_rd(input logic [6:0] a);
        exp_t e;
        e = '{rd: 1'b1, addr: a, wdata: 8'h00};
        exp_q.push_back(e);
    endtask

    task automatic cs_low();
        tick();
        bus.IN_CS = 1'b0;
        repeat (4) tick();
    endtask

    task automatic cs_high();
        tick();
        bus.IN_CS = 1'b1;
        repeat (4) tick();
    endtask

    // One SPI word: READY high for two clocks, then a gap comfortably above the minimum
    task automatic send_frame(input logic [7:0] w);
        tick();
        bus.IN_RX_DATA  = w;
        bus.IN_RX_READY = 1'b1;
        tick();
        tick();
        bus.IN_RX_READY = 1'b0;
        repeat (8) tick();
    endtask

    task automatic run_vec(input vec_t v);
        logic [6:0] a;
        a = v.cmd[6:0];
        if (v.cmd[7]) mem[a] = v.rdata;
        cs_low();
        chk("busy_after_cs_fall", bus.OUT_BUSY, 1'b1);
        chk("err_after_cs_fall", bus.OUT_ERR, 1'b0);
        if (v.cmd[7]) push_rd(a);
        send_frame(v.cmd);
        chk("tx_before_word2", bus.OUT_TX_DATA, v.exp_tx_mid);
        if (!v.cmd[7]) push_wr(a, v.data);
`ifdef SPI_CMD_CTRL_AUTOINC_EN
        if (v.cmd[7]) push_rd(a + 7'd1);
`endif
        send_frame(v.data);
        cs_high();
        chk("tx_after_cs_rise", bus.OUT_TX_DATA, 8'hA5);
        chk("err_end", bus.OUT_ERR, v.exp_err);
        chk("busy_end", bus.OUT_BUSY, 1'b0);
        chk("strobes_outstanding", exp_q.size(), 0);
    endtask

    initial begin
        vecs[0] = '{cmd: 8'h05, data: 8'h3C, rdata: 8'h00, exp_tx_mid: 8'hA5, exp_err: 1'b0};
        vecs[1] = '{cmd: 8'h85, data: 8'h00, rdata: 8'h77, exp_tx_mid: 8'h77, exp_err: 1'b0};
        vecs[2] = '{cmd: 8'h00, data: 8'hFF, rdata: 8'h00, exp_tx_mid: 8'hA5, exp_err: 1'b0};
        vecs[3] = '{cmd: 8'hFF, data: 8'h12, rdata: 8'h5A, exp_tx_mid: 8'h5A, exp_err: 1'b0};
        vecs[4] = '{cmd: 8'h40, data: 8'h81, rdata: 8'h00, exp_tx_mid: 8'hA5, exp_err: 1'b0};
        vecs[5] = '{cmd: 8'h80, data: 8'h00, rdata: 8'hC3, exp_tx_mid: 8'hC3, exp_err: 1'b0};
        for (int i = 0; i < 128; i++) mem[i] = 8'h00;

        rst             = 1'b1;
        bus.IN_CS       = 1'b1;
        bus.IN_RX_READY = 1'b0;
        bus.IN_RX_DATA  = 8'h00;
        repeat (3) tick();
        chk("rst_tx", bus.OUT_TX_DATA, 8'hA5);
        chk("rst_addr", bus.OUT_REG_ADDR, 7'h00);
        chk("rst_wdata", bus.OUT_REG_WDATA, 8'h00);
        chk("rst_strobes", {bus.OUT_REG_WR_EN, bus.OUT_REG_RD_EN}, 2'b00);
        chk("rst_busy_err", {bus.OUT_BUSY, bus.OUT_ERR}, 2'b00);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_busy", bus.OUT_BUSY, 1'b0);

        // Single write/read transactions from the table
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Burst write starting at the top address
        cs_low();
        send_frame(8'h7F);
        push_wr(7'd127, 8'h11);
        send_frame(8'h11);
`ifdef SPI_CMD_CTRL_AUTOINC_EN
        push_wr(7'd0, 8'h22);
`endif
        send_frame(8'h22);
        cs_high();
`ifdef SPI_CMD_CTRL_AUTOINC_EN
        chk("burst_err", bus.OUT_ERR, 1'b0);
`else
        chk("extra_word_err", bus.OUT_ERR, 1'b1);
`endif
        chk("burst_strobes_outstanding", exp_q.size(), 0);

        // Truncated write: command only
        cs_low();
        send_frame(8'h05);
        cs_high();
        chk("trunc_err", bus.OUT_ERR, 1'b1);
        cs_low();
        chk("err_cleared_on_fall", bus.OUT_ERR, 1'b0);
        cs_high();
        chk("empty_cs_no_err", bus.OUT_ERR, 1'b0);

        // Gap violation: second READY pulse two clocks after the read command
        mem[5] = 8'h99;
        cs_low();
        push_rd(7'd5);
        tick();
        bus.IN_RX_DATA  = 8'h85;
        bus.IN_RX_READY = 1'b1;
        tick();
        bus.IN_RX_READY = 1'b0;
        tick();
        bus.IN_RX_READY = 1'b1;
        tick();
        bus.IN_RX_READY = 1'b0;
        repeat (10) tick();
        chk("gap_err", bus.OUT_ERR, 1'b1);
        chk("gap_tx_read_done", bus.OUT_TX_DATA, 8'h99);
        cs_high();
        chk("gap_strobes_outstanding", exp_q.size(), 0);

        // Reset while waiting for write data
        cs_low();
        send_frame(8'h05);
        rst = 1'b1;
        #1;
        chk("midrst_tx", bus.OUT_TX_DATA, 8'hA5);
        chk("midrst_addr", bus.OUT_REG_ADDR, 7'h00);
        chk("midrst_wdata", bus.OUT_REG_WDATA, 8'h00);
        chk("midrst_busy_err", {bus.OUT_BUSY, bus.OUT_ERR}, 2'b00);
        tick();
        rst = 1'b0;
        send_frame(8'h3C);                      // no CS fall seen since reset: must be ignored
        cs_high();
        chk("postrst_busy", bus.OUT_BUSY, 1'b0);
        run_vec('{cmd: 8'h12, data: 8'h34, rdata: 8'h00, exp_tx_mid: 8'hA5, exp_err: 1'b0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
